// File: rtl/tt_uo_uart_capture.sv
// Captures debounced changes of an asynchronous 8-bit tile output into a small FIFO
// and replays each captured byte as an 8N1 LSB-first frame on a single tx pin.
module tt_uo_uart_capture #(
  parameter int DEPTH         = 4,
  parameter int CLKS_PER_BIT  = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic                     enable,
  input  logic                     ovf_clr,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    meta_q, meta_d;
  logic [7:0]    sync_q, sync_d;
  logic [1:0]    prime_q, prime_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic          en_q, en_d;
  logic          first_q, first_d;
  logic [7:0]    last_cap_q, last_cap_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic          tx_q, tx_d;

  logic          stable;
  logic          capture;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          bit_end;
  logic [2:0]    nxt_idx;

  // Capture path: synchroniser, stability filter, capture decision and FIFO bookkeeping.
  always_comb begin
    meta_d  = data_in;
    sync_d  = meta_q;
    // The synchroniser flops hold reset values, not real samples, until primed.
    prime_d = {prime_q[0], 1'b1};

    stab_cnt_d = '0;
    if (prime_q[1] && (meta_q == sync_q)) begin
      stab_cnt_d = (stab_cnt_q == STAB_MAX) ? STAB_MAX : stab_cnt_q + SW'(1);
    end
    stable = prime_q[1] && (stab_cnt_q == STAB_MAX);

    capture = enable && stable && ((sync_q != last_cap_q) || first_q);
    pop     = (state_q == IDLE) && (level_q != '0);
    push_ok = capture && ((level_q != LVL_FULL) || pop);
    drop    = capture && !push_ok;

    en_d    = enable;
    first_d = first_q;
    if (capture) begin
      first_d = 1'b0;
    end
    if (en_q && !enable) begin
      first_d = 1'b1;
    end
    last_cap_d = capture ? sync_q : last_cap_q;

    wptr_d = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop     ? rptr_q + AW'(1) : rptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    ovf_d = drop || (ovf_q && !ovf_clr);

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wptr_q] = sync_q;
    end
  end

  // Serialiser: tx_d is computed for the state being entered so tx is a clean flop output.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    bitidx_d = bitidx_q;
    tx_d     = tx_q;
    bit_end  = (bcnt_q == BIT_LAST);
    nxt_idx  = bitidx_q + 3'd1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          shreg_d = mem_q[rptr_q];
          bcnt_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bcnt_d   = '0;
          bitidx_d = '0;
          tx_d     = shreg_q[0];
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (bitidx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bitidx_d = nxt_idx;
            tx_d     = shreg_q[nxt_idx];
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      prime_q    <= '0;
      stab_cnt_q <= '0;
      en_q       <= 1'b0;
      first_q    <= 1'b1;
      last_cap_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      bitidx_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      prime_q    <= prime_d;
      stab_cnt_q <= stab_cnt_d;
      en_q       <= en_d;
      first_q    <= first_d;
      last_cap_q <= last_cap_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      bitidx_q   <= bitidx_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset: contents are only visible through the reset pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign level    = level_q;

endmodule

// File: doc/tt_uo_uart_capture.md
# tt_uo_uart_capture

Downstream capture stage for a microtile's 8-bit `uo_out` bus. It synchronises the asynchronous combinational output into the `clk` domain and debounces it. Each new stable value goes into a small FIFO, and the block serialises it on a UART-style `tx` line (8N1, LSB first). This lets a bench or board log the tile's response with one pin.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; must be a power of 2, at least 2.
- `CLKS_PER_BIT`, 4: `clk` cycles per serial bit; must be at least 2.
- `STABLE_CYCLES`, 2: consecutive equal synchronised samples needed before a value counts as stable; must be at least 1.

Ports:
- `clk`  in  1: single clock; all state is clocked on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  8: tile `uo_out`; asynchronous to `clk`, and bits may skew.
- `enable`  in  1: capture enable, synchronous.
- `ovf_clr`  in  1: synchronous single-cycle pulse that clears `overflow`.
- `tx`  out  1: serial output; idles high.
- `busy`  out  1: high while the FSM is in any state other than IDLE.
- `overflow`  out  1: sticky flag; set when a stable value is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy, from 0 to DEPTH.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each bit, giving `sync[7:0]`.
- **Stability filter:**
  - A counter increments while `sync` equals the previous `sync`.
  - Any difference resets it to 0.
  - `stable` is asserted when the counter reaches STABLE_CYCLES−1, and the counter saturates there.
- **Capture rule:**
  - Capture happens only while `enable` is 1 and `stable` is 1.
  - A value is pushed when `sync` differs from `last_cap`, or when `first` is set.
  - On a push: `last_cap` takes `sync` and `first` is cleared.
  - Each stable value is pushed exactly once.
- **`first` flag:**
  - Set by reset and on every falling edge of `enable`.
  - This guarantees the baseline value is logged after each enable.
- **FIFO:**
  - DEPTH×8 circular buffer with wrapping read and write pointers; `level` is the count.
  - Push while full: data is dropped and `overflow` is set. `last_cap` is still updated, so the same value is not retried.
  - Push and pop in the same cycle while full: the pop frees an entry and the push is accepted; `level` is unchanged.
  - Push and pop in the same cycle while empty: not possible, because a pop needs `level` > 0 at the start of the cycle.
- **`overflow`:**
  - `ovf_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
- **Serialiser FSM** (states IDLE, START, DATA, STOP):
  - IDLE: `tx`=1. If `level` > 0, pop into `shreg` and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bitidx`=0.
  - DATA: `tx`=`shreg[bitidx]` for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Drain behaviour:** `enable` only gates capture. The FIFO continues to drain while `enable` is 0.
- **`tx` is registered** and driven from the state and shift register; no glitches are allowed.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, `level`=0. All FSM state is IDLE, `last_cap`=0x00, `first`=1, and the stability counter is 0.
- **Reset mid-frame:** `tx` returns high asynchronously. The FIFO contents are discarded.
- **Capture latency:** a change on `data_in` (held constant afterwards) shows up as `level` +1 exactly 2 + STABLE_CYCLES clock edges later, i.e. 2 sync edges plus STABLE_CYCLES stable samples. With defaults, this is at the 4th edge.
- **Pop-to-frame latency:** the pop happens on the edge that leaves IDLE. `tx` falls on that same edge (registered output), and `busy` rises on that same edge.
- **Frame length:** 10×CLKS_PER_BIT cycles, which is 40 with defaults.
- **Back-to-back frames:** there is a 1-cycle IDLE between frames, so the effective stop bit lasts CLKS_PER_BIT+1 cycles.
- **Skew handling:** bit skew between `data_in` lines shorter than STABLE_CYCLES−1 cycles after synchronisation must not produce an intermediate push.
- **`level`** updates on the edge after the push or pop event.

## Test plan
- **Reset and baseline:**
  - Stimulus: hold `data_in`=0x00, release reset, raise `enable`.
  - Required: one push of 0x00. `tx` frame is 0, then eight 0s, then 1; the frame spans 40 cycles. `level` returns to 0 and `busy` falls after STOP.
- **Single change:**
  - Stimulus: `data_in` 0x00 → 0xA5.
  - Required: `level`=1 on the 4th edge after the change. The decoded LSB-first bits are 1,0,1,0,0,1,0,1.
- **Glitch reject:**
  - Stimulus: drive 0x3C for 1 cycle, then return to the prior value 0x00.
  - Required: no push.
  - Stimulus: drive 0x3C for 3 cycles.
  - Required: exactly one push of 0x3C.
- **Overflow:**
  - Stimulus: while `tx` is mid-frame, apply 6 distinct stable values 0x01 to 0x06, each held 3 cycles.
  - Required: `level` saturates at 4 and `overflow`=1. The decoded sequence is the in-flight byte, then 0x01–0x04. 0x05 and 0x06 are dropped.
  - Stimulus: pulse `ovf_clr`.
  - Required: `overflow`=0.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n`=0 during DATA bit 3.
  - Required: `tx`=1 immediately, `level`=0, `busy`=0. After release with `enable`=1, the current value is re-logged because `first` is set.
- **Enable toggle:**
  - Stimulus: `enable` 1 → 0 → 1 with `data_in` constant at 0x7E.
  - Required: 0x7E is logged again after re-enable. While `enable`=0, the FIFO still drains.
